pulse_train_core: RTL and testbench

- Timing engine that sits directly downstream of the AXI4-Lite register slave in fpga_pulse_generator.
- The slave's four 32-bit registers drive this block's ports:
  - reg0 = control (bit0 start strobe, bit1 abort strobe)
  - reg1 = delay
  - reg2 = width/period
  - reg3 = count
- On start, the block latches the configuration and emits a programmable train of rectangular pulses on pulse_out.
- It reports busy/done/pulse index back to the register slave for readback.

---
 rtl/pulse_train_core.sv | 160 ++++++++++++++++
 tb/tb_pulse_train_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_core.sv
// Pulse-train timing engine: latches delay/width/period/count on start and
// drives a registered rectangular pulse train with busy/done/index status.
module pulse_train_core #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NUM_W-1:0] pulse_idx
);

    // state  | meaning
    // IDLE   | waiting for start
    // DELAY  | counting cfg_delay before first pulse
    // HIGH   | pulse_out high for width cycles
    // LOW    | pulse_out low for period - width cycles
    // FINISH | one-cycle done strobe
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        HIGH   = 3'd2,
        LOW    = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [NUM_W-1:0]   count_q, count_d;
    logic [NUM_W-1:0]   idx_q, idx_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cfg_valid;
    logic [NUM_W:0]     idx_inc;
    logic               more_pulses;

    assign cfg_valid   = (cfg_width != '0) && (cfg_period > cfg_width);
    assign idx_inc     = {1'b0, idx_q} + {{NUM_W{1'b0}}, 1'b1};
    assign more_pulses = (count_q == '0) || (idx_inc < {1'b0, count_q});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        period_d = period_q;
        count_d  = count_q;
        idx_d    = idx_q;
        err_d    = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // abort in the same cycle suppresses both start and cfg_err
                    if (start && !abort) begin
                        if (cfg_valid) begin
                            width_d  = cfg_width;
                            period_d = cfg_period;
                            count_d  = cfg_count;
                            idx_d    = '0;
                            if (cfg_delay != '0) begin
                                state_d = DELAY;
                                cnt_d   = cfg_delay - CNT_W'(1);
                            end else begin
                                state_d = HIGH;
                                cnt_d   = cfg_width - CNT_W'(1);
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = HIGH;
                        cnt_d   = width_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt_q == '0) begin
                        state_d = LOW;
                        cnt_d   = period_q - width_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt_q == '0) begin
                        if (more_pulses) begin
                            state_d = HIGH;
                            cnt_d   = width_q - CNT_W'(1);
                            idx_d   = idx_inc[NUM_W-1:0];
                        end else begin
                            state_d = FINISH;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // outputs are registered alongside the state they describe
        pulse_d = (state_d == HIGH);
        busy_d  = (state_d == DELAY) || (state_d == HIGH) || (state_d == LOW);
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            period_q <= period_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_train_core.sv
// Directed bench for pulse_train_core: per-cycle vector table plus
// hand-written continuous/abort and mid-pulse reset sequences.
module tb_pulse_train_core;

    logic        ACLK;
    logic        ARESETN;
    logic        start;
    logic        abort;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_period;
    logic [15:0] cfg_count;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] pulse_idx;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_train_core #(.CNT_W(16), .NUM_W(16)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .start      (start),
        .abort      (abort),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .pulse_idx  (pulse_idx)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        string       tag;
        logic        st;
        logic        ab;
        logic [15:0] dly;
        logic [15:0] wid;
        logic [15:0] per;
        logic [15:0] cnt;
        logic        e_pulse;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic [15:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic vec_t mk(string tag, logic st, logic ab,
                                logic [15:0] dly, logic [15:0] wid, logic [15:0] per, logic [15:0] cnt,
                                logic ep, logic eb, logic ed, logic ee, logic [15:0] ei);
        vec_t v;
        v.tag = tag; v.st = st; v.ab = ab;
        v.dly = dly; v.wid = wid; v.per = per; v.cnt = cnt;
        v.e_pulse = ep; v.e_busy = eb; v.e_done = ed; v.e_err = ee; v.e_idx = ei;
        return v;
    endfunction

    // delay=2 width=3 period=5 count=2, started at local cycle 0
    task automatic add_train(string tag, logic repulse, logic [15:0] idx0);
        for (int c = 0; c <= 14; c++) begin
            logic ep, eb, ed;
            logic [15:0] ei;
            ep = ((c >= 3) && (c <= 5)) || ((c >= 8) && (c <= 10));
            eb = (c >= 1) && (c <= 12);
            ed = (c == 13);
            ei = (c == 0) ? idx0 : ((c >= 8) ? 16'd1 : 16'd0);
            vecs.push_back(mk($sformatf("%s_c%0d", tag, c),
                              (c == 0) || (repulse && c == 4), 1'b0,
                              16'd2, (repulse && c >= 4) ? 16'd1 : 16'd3, 16'd5, 16'd2,
                              ep, eb, ed, 1'b0, ei));
        end
    endtask

    initial begin
        ARESETN = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_delay = '0; cfg_width = '0; cfg_period = '0; cfg_count = '0;

        add_train("train", 1'b0, 16'd0);
        add_train("repulse", 1'b1, 16'd1);
        // delay=0 width=1 period=2 count=1
        vecs.push_back(mk("single_c0", 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 16'd1));
        vecs.push_back(mk("single_c1", 0, 0, 0, 1, 2, 1, 1, 1, 0, 0, 16'd0));
        vecs.push_back(mk("single_c2", 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 16'd0));
        vecs.push_back(mk("single_c3", 0, 0, 0, 1, 2, 1, 0, 0, 1, 0, 16'd0));
        vecs.push_back(mk("single_c4", 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 16'd0));
        // width == period is rejected
        vecs.push_back(mk("inv_wp_c0", 1, 0, 0, 4, 4, 1, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk("inv_wp_c1", 0, 0, 0, 4, 4, 1, 0, 0, 0, 1, 16'd0));
        vecs.push_back(mk("inv_wp_c2", 0, 0, 0, 4, 4, 1, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk("inv_wp_c3", 0, 0, 0, 4, 4, 1, 0, 0, 0, 0, 16'd0));
        // width == 0 is rejected
        vecs.push_back(mk("inv_w0_c0", 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk("inv_w0_c1", 0, 0, 1, 0, 3, 1, 0, 0, 0, 0 | 1'b1, 16'd0));
        vecs.push_back(mk("inv_w0_c2", 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 16'd0));
        // abort + start together in IDLE: nothing happens
        vecs.push_back(mk("abst_c0", 1, 1, 0, 1, 2, 1, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk("abst_c1", 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk("abst_c2", 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 16'd0));
        vecs.push_back(mk("abst_c3", 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 16'd0));

        #3;
        chk("rst_pulse", 32'(pulse_out), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(cfg_err),   32'd0);
        chk("rst_idx",   32'(pulse_idx), 32'd0);
        #9 ARESETN = 1'b1;
        step();

        foreach (vecs[i]) begin
            start      = vecs[i].st;
            abort      = vecs[i].ab;
            cfg_delay  = vecs[i].dly;
            cfg_width  = vecs[i].wid;
            cfg_period = vecs[i].per;
            cfg_count  = vecs[i].cnt;
            chk({vecs[i].tag, "_pulse"}, 32'(pulse_out), 32'(vecs[i].e_pulse));
            chk({vecs[i].tag, "_busy"},  32'(busy),      32'(vecs[i].e_busy));
            chk({vecs[i].tag, "_done"},  32'(done),      32'(vecs[i].e_done));
            chk({vecs[i].tag, "_err"},   32'(cfg_err),   32'(vecs[i].e_err));
            chk({vecs[i].tag, "_idx"},   32'(pulse_idx), 32'(vecs[i].e_idx));
            step();
        end
        start = 1'b0; abort = 1'b0;

        // continuous mode: width=1 period=3 count=0, abort sampled at cycle 20
        cfg_delay = 16'd0; cfg_width = 16'd1; cfg_period = 16'd3; cfg_count = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("cont_pulse_c%0d", c), 32'(pulse_out), 32'((c % 3) == 1));
            chk($sformatf("cont_busy_c%0d", c),  32'(busy),      32'd1);
            chk($sformatf("cont_idx_c%0d", c),   32'(pulse_idx), 32'((c - 1) / 3));
            if (c == 20) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        chk("abort_pulse", 32'(pulse_out), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_done",  32'(done),      32'd0);
        chk("abort_idx",   32'(pulse_idx), 32'd6);
        step();
        chk("abort_done2", 32'(done),      32'd0);
        chk("abort_idx2",  32'(pulse_idx), 32'd6);

        // asynchronous reset in the middle of a HIGH phase
        cfg_delay = 16'd0; cfg_width = 16'd5; cfg_period = 16'd8; cfg_count = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("prerst_pulse", 32'(pulse_out), 32'd1);
        chk("prerst_busy",  32'(busy),      32'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_pulse", 32'(pulse_out), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_idx",   32'(pulse_idx), 32'd0);
        step();
        ARESETN = 1'b1;
        step();
        step();
        chk("postrst_pulse", 32'(pulse_out), 32'd0);
        chk("postrst_busy",  32'(busy),      32'd0);
        chk("postrst_done",  32'(done),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
